write_buffer_ctrl: RTL and testbench
====================================

// Module: write_buffer_ctrl
// PURPOSE
//   Drain controller and back-end arbiter for the cache write buffer FIFO.
//   Pops buffered write-through entries and issues them as back-end memory
//   writes, and shares the same back-end port with line-fill read requests.
//   Reads are served only when the write buffer is empty and no write is in
//   flight, so a read can never bypass an older buffered write.
// PARAMETERS
//   ADDR_W   32                        back-end address width (bits)
//   DATA_W   32                        back-end data width (bits), multiple of 8
//   N_BYTES  DATA_W/8                  write strobe width
//   WORD_W   ADDR_W+N_BYTES+DATA_W     FIFO word; packing {addr, wstrb, data}
// PORTS
//   clock         in   1        system clock, all logic on posedge
//   reset         in   1        synchronous, active-high
//   fifo_empty    in   1        write buffer empty flag
//   fifo_rd       out  1        FIFO pop; FIFO dataout valid the following cycle
//   fifo_dataout  in   WORD_W   FIFO head word, {addr, wstrb, data}
//   rd_req        in   1        line-fill read request, level, held until rd_ack
//   rd_addr       in   ADDR_W   read address, stable while rd_req high
//   rd_ack        out  1        one-cycle read-complete pulse
//   rd_rdata      out  DATA_W   read data; valid with rd_ack, held until next read
//   mem_valid     out  1        back-end request valid
//   mem_addr      out  ADDR_W   back-end address
//   mem_wdata     out  DATA_W   back-end write data
//   mem_wstrb     out  N_BYTES  byte strobes; all-zero = read
//   mem_rdata     in   DATA_W   back-end read data, valid when mem_ready high
//   mem_ready     in   1        back-end accept/complete
//   busy          out  1        (state != IDLE) | ~fifo_empty
// BEHAVIOUR
//   Reset (sync): state IDLE; mem_valid, mem_addr, mem_wdata, mem_wstrb,
//     rd_ack, rd_rdata all 0; fifo_rd 0. Reset mid-transaction drops mem_valid
//     at the reset edge; a popped, unwritten entry is discarded (FIFO shares reset).
//   States: IDLE, POP, LOAD, WRITE, READ, ACK. fifo_rd = (state==POP).
//   IDLE : ~fifo_empty -> POP (writes win); else rd_req -> READ, registering
//          mem_addr=rd_addr, mem_wstrb=0, mem_wdata=0, mem_valid=1.
//   POP  : fifo_rd high exactly one cycle -> LOAD.
//   LOAD : capture fifo_dataout into mem_addr/mem_wstrb/mem_wdata, mem_valid<=1
//          -> WRITE.
//   WRITE: hold mem_valid and all mem_* stable until mem_ready sampled high;
//          at that edge mem_valid<=0 -> IDLE.
//   READ : hold until mem_ready; at that edge rd_rdata<=mem_rdata, rd_ack<=1,
//          mem_valid<=0 -> ACK.
//   ACK  : rd_ack high this cycle only; -> IDLE. Requester drops rd_req here.
//   Latency: fifo_empty low in IDLE cycle t -> fifo_rd cycle t+1 -> mem_valid
//     from t+3. rd_req in IDLE (fifo empty) cycle t -> mem_valid from t+1.
//   mem_ready high in the first mem_valid cycle completes in that cycle.
//   mem_ready ignored while mem_valid low. Zero-strobe FIFO entries still issue.
//   fifo_rd never asserted when fifo_empty was high in the deciding IDLE cycle.
//   New FIFO entries during READ/ACK wait; read already issued is not aborted.
//   rd_req arriving while writes pending waits until FIFO drained (no timeout).
// TESTING
//   1 reset asserted 2 cycles mid-stream -> all outputs 0, fifo_rd 0, busy=0
//     after reset with empty FIFO.
//   2 one entry {0x100, 0xF, 0xDEADBEEF}, mem_ready=1 -> fifo_rd 1 cycle;
//     mem_valid exactly 1 cycle, 2 cycles later, with addr 0x100, wdata/wstrb.
//   3 same entry, mem_ready low 5 cycles -> mem_valid/addr/wdata stable 6
//     cycles; no second fifo_rd until after completion.
//   4 FIFO holds 2 entries, rd_req addr 0x200 same cycle -> both writes complete
//     first, then read wstrb=0 addr 0x200; rd_ack 1 cycle, rd_rdata=0x12345678.
//   5 empty FIFO, rd_req addr 0x40, mem_ready after 3 cycles -> mem_valid next
//     cycle for 4 cycles, rd_ack pulse after completion, busy low afterwards.
//   6 reset in WRITE with mem_ready low -> mem_valid 0 next cycle, state IDLE.

Source files
------------

// File: rtl/write_buffer_ctrl.sv
// Write-buffer drain controller: pops FIFO entries into back-end writes and
// shares the back-end port with line-fill reads, which wait for an empty buffer.
module write_buffer_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int N_BYTES = DATA_W / 8,
  parameter int WORD_W  = ADDR_W + N_BYTES + DATA_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               fifo_empty,
  output logic               fifo_rd,
  input  logic [WORD_W-1:0]  fifo_dataout,
  input  logic               rd_req,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic               rd_ack,
  output logic [DATA_W-1:0]  rd_rdata,
  output logic               mem_valid,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic [N_BYTES-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ready,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4,
    ACK   = 3'd5
  } state_t;

  state_t state;

  assign busy = (state != IDLE) | ~fifo_empty;

  // Drain/arbitration FSM; every back-end and requester output is a flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      fifo_rd   <= 1'b0;
      rd_ack    <= 1'b0;
      rd_rdata  <= '0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Buffered writes always win so a read never overtakes an older write.
          if (!fifo_empty) begin
            state   <= POP;
            fifo_rd <= 1'b1;
          end else if (rd_req) begin
            state     <= READ;
            mem_addr  <= rd_addr;
            mem_wstrb <= '0;
            mem_wdata <= '0;
            mem_valid <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        POP: begin
          fifo_rd <= 1'b0;
          state   <= LOAD;
        end
        LOAD: begin
          mem_addr  <= fifo_dataout[WORD_W-1 -: ADDR_W];
          mem_wstrb <= fifo_dataout[DATA_W +: N_BYTES];
          mem_wdata <= fifo_dataout[DATA_W-1:0];
          mem_valid <= 1'b1;
          state     <= WRITE;
        end
        WRITE: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            state <= WRITE;
          end
        end
        READ: begin
          if (mem_ready) begin
            rd_rdata  <= mem_rdata;
            rd_ack    <= 1'b1;
            mem_valid <= 1'b0;
            state     <= ACK;
          end else begin
            state <= READ;
          end
        end
        ACK: begin
          rd_ack <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state     <= IDLE;
          fifo_rd   <= 1'b0;
          rd_ack    <= 1'b0;
          mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_write_buffer_ctrl.sv
// Scoreboard bench for write_buffer_ctrl: FIFO and back-end models, expected
// transactions queued at stimulus time and checked by a negedge monitor.
module tb_write_buffer_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int WW = AW + NB + DW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_empty;
  logic          fifo_rd;
  logic [WW-1:0] fifo_dataout = '0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_ack;
  logic [DW-1:0] rd_rdata;
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [NB-1:0] mem_wstrb;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          busy;

  write_buffer_ctrl dut (
    .clock(clock), .reset(reset), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .fifo_dataout(fifo_dataout), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_rdata(rd_rdata), .mem_valid(mem_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [NB-1:0] strb;
    logic [DW-1:0] data;
    int            len;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] exp_rd[$];

  logic [WW-1:0] fmem [16];
  int wp = 0;
  int rp = 0;
  int lat = 0;

  assign fifo_empty = (wp == rp);

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // FIFO model: a pop presents the head word the following cycle; reset discards all.
  always @(posedge clock) begin
    if (reset) begin
      rp <= wp;
    end else if (fifo_rd) begin
      fifo_dataout <= fmem[rp % 16];
      rp <= rp + 1;
    end
  end

  // Back-end model: completes after 'lat' wait cycles of mem_valid.
  initial begin
    int rcnt;
    rcnt = 0;
    forever begin
      @(posedge clock);
      #1;
      if (reset || !mem_valid) begin
        rcnt = 0;
        mem_ready = 1'b0;
      end else begin
        mem_ready = (rcnt >= lat);
        rcnt++;
      end
    end
  end

  // Monitor: inputs and outputs are all stable at the falling edge.
  initial begin
    int run;
    int cyc;
    int pop_cyc;
    bit prev_valid;
    bit prev_ack;
    logic [AW+NB+DW-1:0] prev_fields;
    exp_t e;
    run = 0; cyc = 0; pop_cyc = -1; prev_valid = 1'b0; prev_ack = 1'b0; prev_fields = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        run = 0;
        pop_cyc = -1;
        prev_valid = 1'b0;
        prev_ack = 1'b0;
      end else begin
        if (fifo_rd) begin
          check("pop_nonempty", 96'(wp != rp), 96'd1);
          check("pop_during_mem", 96'(mem_valid), 96'd0);
          pop_cyc = cyc;
        end
        if (mem_valid) begin
          if (!prev_valid) begin
            run = 1;
            if (pop_cyc >= 0) begin
              check("pop_to_valid", 96'(cyc - pop_cyc), 96'd2);
              pop_cyc = -1;
            end
          end else begin
            run++;
            check("mem_stable", 96'({mem_addr, mem_wstrb, mem_wdata}), 96'(prev_fields));
          end
          if (mem_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_txn: got addr %0h with nothing expected", mem_addr);
            end else begin
              e = exp_q.pop_front();
              check("mem_addr", 96'(mem_addr), 96'(e.addr));
              check("mem_wstrb", 96'(mem_wstrb), 96'(e.strb));
              check("mem_wdata", 96'(mem_wdata), 96'(e.data));
              check("valid_len", 96'(run), 96'(e.len));
            end
          end
        end
        if (rd_ack) begin
          check("ack_one_cycle", 96'(prev_ack), 96'd0);
          if (exp_rd.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack: got rd_rdata %0h with nothing expected", rd_rdata);
          end else begin
            check("rd_rdata", 96'(rd_rdata), 96'(exp_rd.pop_front()));
          end
        end
        prev_valid = mem_valid;
        prev_ack = rd_ack;
        prev_fields = {mem_addr, mem_wstrb, mem_wdata};
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_entry(input logic [AW-1:0] a, input logic [NB-1:0] s,
                            input logic [DW-1:0] d, input int len, input bit expect_txn);
    exp_t e;
    fmem[wp % 16] = {a, s, d};
    wp++;
    if (expect_txn) begin
      e.addr = a; e.strb = s; e.data = d; e.len = len;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int len, input bit chk_lat);
    exp_t e;
    bit got;
    e.addr = a; e.strb = '0; e.data = '0; e.len = len;
    exp_q.push_back(e);
    exp_rd.push_back(d);
    mem_rdata = d;
    rd_req = 1'b1;
    rd_addr = a;
    if (chk_lat) begin
      tick();
      check("rd_req_to_valid", 96'(mem_valid), 96'd1);
    end
    got = rd_ack;
    for (int k = 0; k < 200 && !got; k++) begin
      tick();
      got = rd_ack;
    end
    check("rd_ack_seen", 96'(got), 96'd1);
    rd_req = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      tick();
      done = (exp_q.size() == 0) && (exp_rd.size() == 0) && (busy == 1'b0);
    end
    check({name, "_drained"}, 96'(done), 96'd1);
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = mem_valid;
    for (int k = 0; k < 50 && !seen; k++) begin
      tick();
      seen = mem_valid;
    end
    check({name, "_valid_seen"}, 96'(seen), 96'd1);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_mem_valid"}, 96'(mem_valid), 96'd0);
    check({name, "_fifo_rd"}, 96'(fifo_rd), 96'd0);
    check({name, "_rd_ack"}, 96'(rd_ack), 96'd0);
    check({name, "_rd_rdata"}, 96'(rd_rdata), 96'd0);
    check({name, "_mem_fields"}, 96'({mem_addr, mem_wstrb, mem_wdata}), 96'd0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    check_outputs_zero("reset");
    check("reset_busy", 96'(busy), 96'd0);
    reset = 1'b0;
    tick();

    // single write, immediate completion
    lat = 0;
    push_entry(32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 1, 1'b1);
    drain("t2");

    // two writes, each stalled 5 cycles
    lat = 5;
    push_entry(32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 6, 1'b1);
    push_entry(32'h0000_0108, 4'h1, 32'h0000_00AB, 6, 1'b1);
    drain("t3");

    // read on empty FIFO, 3 wait cycles
    lat = 3;
    do_read(32'h0000_0040, 32'hCAFE_F00D, 4, 1'b1);
    drain("t5");

    // writes and read request together: writes drain first
    lat = 0;
    push_entry(32'h0000_0300, 4'h3, 32'hA5A5_0001, 1, 1'b1);
    push_entry(32'h0000_0304, 4'hC, 32'h5A5A_0002, 1, 1'b1);
    do_read(32'h0000_0200, 32'h1234_5678, 1, 1'b0);
    drain("t4");

    // two-cycle reset in the middle of a stalled write
    lat = 8;
    push_entry(32'h0000_0500, 4'hF, 32'h1111_1111, 9, 1'b0);
    push_entry(32'h0000_0504, 4'hF, 32'h2222_2222, 9, 1'b0);
    wait_valid("t1");
    reset = 1'b1;
    tick();
    tick();
    check_outputs_zero("t1");
    check("t1_busy", 96'(busy), 96'd0);
    reset = 1'b0;
    tick();
    check("t1_busy_after", 96'(busy), 96'd0);
    check("t1_fifo_rd_after", 96'(fifo_rd), 96'd0);

    // one-cycle reset while WRITE waits on mem_ready
    lat = 20;
    push_entry(32'h0000_0600, 4'h5, 32'h3333_3333, 21, 1'b0);
    wait_valid("t6");
    tick();
    reset = 1'b1;
    tick();
    check("t6_mem_valid", 96'(mem_valid), 96'd0);
    check("t6_busy", 96'(busy), 96'd0);
    reset = 1'b0;
    tick();
    check("t6_idle", 96'(busy), 96'd0);

    // normal operation resumes, zero-strobe entry still issues
    lat = 1;
    push_entry(32'h0000_0700, 4'h0, 32'h4444_4444, 2, 1'b1);
    drain("recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
